// File: rtl/count_frame_packer.sv
// Snapshots the counter of each newly selected channel and streams it out as a
// header/channel/count/checksum byte frame on a valid/ready byte interface.
module count_frame_packer #(
  parameter int unsigned NUM_CH   = 16,
  parameter int unsigned CNT_W    = 32,
  parameter logic [7:0]  HDR_BYTE = 8'hA5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [3:0]              selection_i,
  input  logic [NUM_CH*CNT_W-1:0] counts_flat_i,
  input  logic                    tx_ready_i,
  output logic [7:0]              tx_data_o,
  output logic                    tx_valid_o,
  output logic                    busy_o,
  output logic                    overrun_o
);

  localparam int unsigned NB   = CNT_W / 8;
  localparam int unsigned BI_W = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [2:0] {StIdle, StHdr, StChan, StData, StCsum} state_e;

  state_e           state_q;
  logic [3:0]       sel_s1_q, sel_s2_q, last_sel_q, ch_q, pend_idx_q;
  logic             pending_q, overrun_q, tx_valid_q;
  logic [7:0]       tx_data_q, csum_q;
  logic [CNT_W-1:0] snap_q;
  logic [BI_W-1:0]  byte_idx_q;

  logic             req, hs, launch, req_to_slot;
  logic [3:0]       launch_idx;
  logic [CNT_W-1:0] launch_cnt;
  logic [7:0]       top_byte;

  always_comb begin
    req         = (sel_s2_q != last_sel_q) && (32'(sel_s2_q) < NUM_CH);
    hs          = tx_valid_q & tx_ready_i;
    launch      = ((state_q == StIdle) && (pending_q || req)) ||
                  ((state_q == StCsum) && hs && pending_q);
    // A queued request always launches before a fresh one.
    launch_idx  = pending_q ? pend_idx_q : sel_s2_q;
    req_to_slot = req && !(launch && !pending_q);
    launch_cnt  = counts_flat_i[launch_idx*CNT_W +: CNT_W];
    top_byte    = snap_q[CNT_W-1 -: 8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      sel_s1_q   <= '0;
      sel_s2_q   <= '0;
      last_sel_q <= '0;
      ch_q       <= '0;
      pend_idx_q <= '0;
      pending_q  <= 1'b0;
      overrun_q  <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      csum_q     <= '0;
      snap_q     <= '0;
      byte_idx_q <= '0;
    end else begin
      sel_s1_q   <= selection_i;
      sel_s2_q   <= sel_s1_q;
      last_sel_q <= sel_s2_q;

      // Overrun only when a still-queued index is lost, not when the slot drains this cycle.
      if (req_to_slot) begin
        pending_q  <= 1'b1;
        pend_idx_q <= sel_s2_q;
        if (pending_q && !launch) overrun_q <= 1'b1;
      end else if (launch && pending_q) begin
        pending_q <= 1'b0;
      end

      if (launch) begin
        state_q    <= StHdr;
        snap_q     <= launch_cnt;
        ch_q       <= launch_idx;
        tx_data_q  <= HDR_BYTE;
        tx_valid_q <= 1'b1;
      end else if (hs) begin
        case (state_q)
          StHdr: begin
            state_q   <= StChan;
            tx_data_q <= {4'h0, ch_q};
            csum_q    <= {4'h0, ch_q};
          end
          StChan: begin
            state_q    <= StData;
            tx_data_q  <= top_byte;
            csum_q     <= csum_q ^ top_byte;
            snap_q     <= snap_q << 8;
            byte_idx_q <= '0;
          end
          StData: begin
            if (byte_idx_q == BI_W'(NB - 1)) begin
              state_q   <= StCsum;
              tx_data_q <= csum_q;
            end else begin
              tx_data_q  <= top_byte;
              csum_q     <= csum_q ^ top_byte;
              snap_q     <= snap_q << 8;
              byte_idx_q <= byte_idx_q + 1'b1;
            end
          end
          StCsum: begin
            state_q    <= StIdle;
            tx_valid_q <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  assign tx_data_o  = tx_data_q;
  assign tx_valid_o = tx_valid_q;
  assign busy_o     = (state_q != StIdle);
  assign overrun_o  = overrun_q;

endmodule

// File: tb/tb_count_frame_packer.sv
// Directed bench for count_frame_packer: expected frames are built from the frame rules and
// checked byte-by-byte on every handshake, with stall stability checked on every stalled cycle.
module tb_count_frame_packer;

  localparam int unsigned NUM_CH = 16;
  localparam int unsigned CNT_W  = 32;
  localparam int unsigned NB     = CNT_W / 8;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [3:0]              selection;
  logic [NUM_CH*CNT_W-1:0] counts_flat;
  logic                    tx_ready;
  logic [7:0]              tx_data;
  logic                    tx_valid, busy, overrun;

  logic [CNT_W-1:0] cnt [NUM_CH];

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  logic [7:0]  exp_q [$];
  logic [7:0]  log_b [$];
  int          log_c [$];
  logic        rdy_mode = 1'b0;

  count_frame_packer #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .HDR_BYTE(8'hA5)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .selection_i  (selection),
    .counts_flat_i(counts_flat),
    .tx_ready_i   (tx_ready),
    .tx_data_o    (tx_data),
    .tx_valid_o   (tx_valid),
    .busy_o       (busy),
    .overrun_o    (overrun)
  );

  always #5 clk = ~clk;

  always_comb begin
    counts_flat = '0;
    for (int k = 0; k < NUM_CH; k++) counts_flat[k*CNT_W +: CNT_W] = cnt[k];
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  // Frame rule: header, channel, count bytes MSB first, XOR of channel and count bytes.
  function automatic void push_frame(input logic [3:0] ch, input logic [CNT_W-1:0] v);
    logic [7:0] cs, b;
    exp_q.push_back(8'hA5);
    exp_q.push_back({4'h0, ch});
    cs = {4'h0, ch};
    for (int i = 0; i < NB; i++) begin
      b = v[CNT_W-1-8*i -: 8];
      exp_q.push_back(b);
      cs = cs ^ b;
    end
    exp_q.push_back(cs);
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Ready driver: constant high, or the repeating pattern 1,0,0,1.
  initial begin
    logic [3:0] pat;
    int k;
    pat = 4'b1001;
    k = 0;
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode) begin
        tx_ready = pat[k % 4];
        k++;
      end else begin
        tx_ready = 1'b1;
        k = 0;
      end
    end
  end

  // Compare process.
  initial begin
    logic       hold;
    logic [7:0] hold_data;
    hold = 1'b0;
    hold_data = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          check("stall_valid", tx_valid, 1);
          check("stall_data", tx_data, hold_data);
        end
        if (tx_valid && tx_ready) begin
          log_b.push_back(tx_data);
          log_c.push_back(cyc);
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_byte: got %0h, expected no byte", tx_data);
          end else begin
            check("frame_byte", tx_data, exp_q.pop_front());
          end
        end
        hold = tx_valid && !tx_ready;
        hold_data = tx_data;
      end
    end
  end

  task automatic set_sel(input logic [3:0] s);
    @(posedge clk);
    #1 selection = s;
  endtask

  task automatic wait_valid();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tx_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check("wait_valid_timeout", ok, 1);
  endtask

  task automatic wait_done();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    check("frame_done_timeout", ok, 1);
  endtask

  task automatic clear_log();
    log_b.delete();
    log_c.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    selection = '0;
    for (int k = 0; k < NUM_CH; k++) cnt[k] = '0;

    // 1: reset state and quiet after release with selection 0
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", tx_valid, 0);
    check("rst_data", tx_data, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("t1_idle_valid", tx_valid, 0);
    end
    check("t1_busy", busy, 0);
    check("t1_overrun", overrun, 0);

    // 2: basic frame, latency and back-to-back bytes
    cnt[3] = 32'h1234_5678;
    push_frame(4'd3, cnt[3]);
    clear_log();
    set_sel(4'd3);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("t2_no_hdr_yet", tx_valid, 0);
    @(negedge clk);
    check("t2_hdr_valid", tx_valid, 1);
    check("t2_hdr_data", tx_data, 8'hA5);
    wait_done();
    check("t2_len", log_b.size(), 7);
    if (log_b.size() == 7) begin
      check("t2_csum", log_b[6], 8'h0B);
      check("t2_msb", log_b[2], 8'h12);
      check("t2_consec", log_c[6] - log_c[0], 6);
    end

    // 3: same count value with tx_ready toggling
    cnt[2] = 32'h1234_5678;
    push_frame(4'd2, cnt[2]);
    clear_log();
    rdy_mode = 1'b1;
    set_sel(4'd2);
    wait_done();
    rdy_mode = 1'b0;
    check("t3_len", log_b.size(), 7);
    if (log_b.size() == 7) check("t3_stalled", (log_c[6] - log_c[0]) > 6, 1);
    check("t3_overrun", overrun, 0);

    // 4: two changes during a frame; only the newest is sent, back-to-back
    cnt[1] = 32'hA1B2_C3D4;
    cnt[5] = 32'h5555_5555;
    cnt[6] = 32'h6666_6666;
    push_frame(4'd1, cnt[1]);
    push_frame(4'd6, cnt[6]);
    clear_log();
    set_sel(4'd1);
    wait_valid();
    set_sel(4'd5);
    @(posedge clk);
    set_sel(4'd6);
    wait_done();
    check("t4_overrun", overrun, 1);
    check("t4_len", log_b.size(), 14);
    if (log_b.size() == 14) begin
      check("t4_second_ch", log_b[8], 8'h06);
      check("t4_back_to_back", log_c[13] - log_c[0], 13);
    end

    // 5: counter changes mid-frame; frame carries the snapshot
    push_frame(4'd3, 32'h1234_5678);
    clear_log();
    set_sel(4'd3);
    wait_valid();
    @(posedge clk);
    #1 cnt[3] = 32'hFFFF_0000;
    wait_done();
    check("t5_len", log_b.size(), 7);
    if (log_b.size() == 7) check("t5_snap_byte", log_b[5], 8'h78);

    // 6: reset pulse during a data byte
    cnt[9] = 32'hCAFE_F00D;
    push_frame(4'd9, cnt[9]);
    clear_log();
    set_sel(4'd9);
    wait_valid();
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("t6_abort_valid", tx_valid, 0);
    check("t6_abort_busy", busy, 0);
    check("t6_abort_overrun", overrun, 0);
    selection = 4'd0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("t6_quiet_valid", tx_valid, 0);
    end
    cnt[4] = 32'h0000_0001;
    push_frame(4'd4, cnt[4]);
    clear_log();
    set_sel(4'd4);
    wait_done();
    check("t6_len", log_b.size(), 7);
    if (log_b.size() == 7) check("t6_csum", log_b[6], 8'h05);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
